// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: data width, RV32I
// load/store funct3 codes, FSM state encoding and request-decode helpers.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (f3[1:0] == 2'b10) bad = (off != 2'b00);
    if (f3[1:0] == 2'b01) bad = off[0];
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the data-RAM port
// of the load/store unit. The unit is the slave, pipeline + RAM the master.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16
);
  import mem_pkg::*;

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both 1; req_* are don't-care otherwise. resp_valid is a
  // single-cycle pulse with no back-pressure; resp_error qualifies it.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_store_data;

  logic              resp_valid;
  logic              resp_error;
  logic [XLEN-1:0]   resp_load_data;

  logic              ram_write_enable;
  logic [ADDR_W-1:0] ram_endereco;
  logic [XLEN-1:0]   ram_data_in;
  logic [XLEN-1:0]   ram_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_store_data,
    input  ram_data_out,
    output req_ready, resp_valid, resp_error, resp_load_data,
    output ram_write_enable, ram_endereco, ram_data_in
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_store_data,
    output ram_data_out,
    input  req_ready, resp_valid, resp_error, resp_load_data,
    input  ram_write_enable, ram_endereco, ram_data_in
  );

endinterface

// File: rtl/mem_align_ext.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a
// RAM word for loads, and merges store data into that word for sb/sh.
module mem_align_ext
  import mem_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      byte_off_i,
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic [XLEN-1:0] load_data_o,
  output logic [XLEN-1:0] merged_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[{byte_off_i, 3'b000} +: 8];
    half_lane = word_i[{byte_off_i[1], 4'b0000} +: 16];

    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_data_o = word_i;
      F3_BU:   load_data_o = {24'h0, byte_lane};
      F3_HU:   load_data_o = {16'h0, half_lane};
      default: load_data_o = '0;
    endcase

    // word_i is the old RAM word here, so untouched lanes are preserved.
    merged_o = word_i;
    case (funct3_i)
      F3_B:    merged_o[{byte_off_i, 3'b000} +: 8]     = store_data_i[7:0];
      F3_H:    merged_o[{byte_off_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      F3_W:    merged_o = store_data_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide RAM without byte enables:
// validates requests, maps byte to word addresses, does RMW for sb/sh.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  mem_access_unit_if.slave bus,
  output state_t           dbg_state_o
);

  state_t              state_q;
  logic                write_q;
  logic                err_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [XLEN-1:0]     data_q;

  logic                req_err;
  logic [XLEN-1:0]     load_ext;
  logic [XLEN-1:0]     merged;

  always_comb begin
    req_err = !f3_valid(bus.req_write, bus.req_funct3)
           || misaligned(bus.req_funct3, bus.req_addr[1:0])
           || (|bus.req_addr[XLEN-1:ADDR_W+2]);
  end

  // Only the in-range address bits are kept; the rest are checked at accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            err_q   <= req_err;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[ADDR_W+1:0];
            data_q  <= bus.req_store_data;
            if (req_err)
              state_q <= ST_RESP;
            else if (bus.req_write && bus.req_funct3 == F3_W)
              state_q <= ST_WRITE;
            else
              state_q <= ST_READ;
          end
        end
        ST_READ:  state_q <= write_q ? ST_WRITE : ST_RESP;
        ST_WRITE: state_q <= ST_RESP;
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  mem_align_ext u_align (
    .funct3_i     (f3_q),
    .byte_off_i   (addr_q[1:0]),
    .word_i       (bus.ram_data_out),
    .store_data_i (data_q),
    .load_data_o  (load_ext),
    .merged_o     (merged)
  );

  // Write enable is gated by reset so an aborted RMW never reaches the RAM.
  always_comb begin
    bus.req_ready        = (state_q == ST_IDLE);
    bus.resp_valid       = (state_q == ST_RESP);
    bus.resp_error       = (state_q == ST_RESP) && err_q;
    bus.resp_load_data   = ((state_q == ST_RESP) && !err_q && !write_q) ? load_ext : '0;
    bus.ram_write_enable = (state_q == ST_WRITE) && !reset;
    bus.ram_endereco     = (state_q == ST_READ || state_q == ST_WRITE)
                           ? addr_q[ADDR_W+1:2] : '0;
    bus.ram_data_in      = (state_q == ST_WRITE) ? merged : '0;
    dbg_state_o          = state_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 64Kx32 registered RAM
// (read-before-write) and a backdoor preload port.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic   clock;
  logic   reset;
  state_t dbg_state;

  mem_access_unit_if #(.ADDR_W(16)) bus ();

  mem_access_unit #(.ADDR_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- RAM model ----------------
  logic [31:0] ram [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;

  always @(posedge clock) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.ram_write_enable) ram[bus.ram_endereco] <= bus.ram_data_in;
    bus.ram_data_out <= ram[bus.ram_endereco];
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  int          r_lat;
  int          r_we;
  logic        r_err;
  logic [31:0] r_ld;
  logic        r_dirty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_load(input logic [15:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
    int  n;
    bit  done;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_store_data = data;
    step();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_store_data = '0;
    n = 0; done = 0; r_lat = 0; r_we = 0; r_err = 0; r_ld = '0; r_dirty = 0;
    while (!done && n < 8) begin
      n++;
      if (bus.ram_write_enable && r_we == 0) r_we = n;
      if (bus.resp_valid) begin
        done = 1; r_lat = n; r_err = bus.resp_error; r_ld = bus.resp_load_data;
      end else begin
        if (bus.resp_load_data !== '0 || bus.resp_error !== 1'b0) r_dirty = 1;
        step();
      end
    end
    check("resp_timeout", 32'(done), 32'd1);
    step();
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'hA5A5_5A5A);
    check({tag, "_lat"}, r_lat, 32'd2);
    check({tag, "_err"}, 32'(r_err), 32'd0);
    check({tag, "_data"}, r_ld, exp);
    check({tag, "_hyg"}, 32'(r_dirty), 32'd0);
  endtask

  task automatic store_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [15:0] widx,
                            input logic [31:0] exp_word, input int exp_lat);
    do_req(1'b1, f3, addr, data);
    check({tag, "_lat"}, r_lat, exp_lat);
    check({tag, "_we_cycle"}, r_we, exp_lat - 1);
    check({tag, "_err"}, 32'(r_err), 32'd0);
    check({tag, "_ld_zero"}, r_ld, 32'd0);
    check({tag, "_word"}, ram[widx], exp_word);
  endtask

  task automatic err_case(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
    do_req(wr, f3, addr, 32'hFFFF_FFFF);
    check({tag, "_lat"}, r_lat, 32'd1);
    check({tag, "_err"}, 32'(r_err), 32'd1);
    check({tag, "_no_we"}, r_we, 32'd0);
    check({tag, "_ld_zero"}, r_ld, 32'd0);
  endtask

  // ---------------- back-to-back stream ----------------
  logic        seq_wr   [5];
  logic [2:0]  seq_f3   [5];
  logic [31:0] seq_addr [5];
  logic [31:0] seq_data [5];
  logic [31:0] seq_ld   [5];
  int          seq_gap  [4];
  int          acc      [5];

  task automatic run_b2b();
    int k;
    logic [31:0] e;
    k = 0;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 40 && !(k == 5 && exp_q.size() == 0); c++) begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) check("b2b_extra_resp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("b2b_resp_data", bus.resp_load_data, e);
        end
      end
      if (bus.req_ready) begin
        if (k < 5) begin
          bus.req_write = seq_wr[k]; bus.req_funct3 = seq_f3[k];
          bus.req_addr = seq_addr[k]; bus.req_store_data = seq_data[k];
          exp_q.push_back(seq_ld[k]);
          acc[k] = c;
          k++;
        end else bus.req_valid = 1'b0;
      end
      step();
    end
    bus.req_valid = 1'b0;
    check("b2b_accepted", k, 32'd5);
    check("b2b_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 4; i++) check("b2b_gap", acc[i+1] - acc[i], seq_gap[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_store_data = '0;
    step(); step();
    reset = 1'b0;

    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check("rst_load_data", bus.resp_load_data, 32'd0);
    check("rst_we", 32'(bus.ram_write_enable), 32'd0);
    check("rst_addr", 32'(bus.ram_endereco), 32'd0);
    check("rst_din", bus.ram_data_in, 32'd0);

    bd_load(16'd5, 32'h8070_F0A5);
    bd_load(16'hFFFF, 32'hCAFE_F00D);

    load_case("lb_15",  F3_B,  32'h15, 32'hFFFF_FFF0);
    load_case("lbu_15", F3_BU, 32'h15, 32'h0000_00F0);
    load_case("lh_16",  F3_H,  32'h16, 32'hFFFF_8070);
    load_case("lhu_16", F3_HU, 32'h16, 32'h0000_8070);
    load_case("lw_14",  F3_W,  32'h14, 32'h8070_F0A5);
    load_case("lb_14",  F3_B,  32'h14, 32'hFFFF_FFA5);
    load_case("lbu_17", F3_BU, 32'h17, 32'h0000_0080);
    load_case("lw_top", F3_W,  32'h0003_FFFC, 32'hCAFE_F00D);

    store_case("sw_20", F3_W, 32'h20, 32'hDEAD_BEEF, 16'd8, 32'hDEAD_BEEF, 2);
    load_case("lw_20", F3_W, 32'h20, 32'hDEAD_BEEF);

    bd_load(16'd8, 32'h1122_3344);
    store_case("sb_23", F3_B, 32'h23, 32'h1234_56AB, 16'd8, 32'hAB22_3344, 3);
    store_case("sh_20", F3_H, 32'h20, 32'h9876_CDEF, 16'd8, 32'hAB22_CDEF, 3);
    store_case("sb_21", F3_B, 32'h21, 32'h0000_0055, 16'd8, 32'hAB22_55EF, 3);
    store_case("sh_22", F3_H, 32'h22, 32'h0000_BEEF, 16'd8, 32'hBEEF_55EF, 3);
    load_case("lhu_22", F3_HU, 32'h22, 32'h0000_BEEF);
    load_case("lb_21",  F3_B,  32'h21, 32'h0000_0055);

    err_case("err_lw_22",   1'b0, F3_W,   32'h22);
    err_case("err_sh_21",   1'b1, F3_H,   32'h21);
    err_case("err_f3_011",  1'b0, 3'b011, 32'h20);
    err_case("err_range",   1'b0, F3_W,   32'h0004_0000);
    err_case("err_st_f3_4", 1'b1, F3_BU,  32'h20);
    err_case("err_f3_110",  1'b0, 3'b110, 32'h20);
    err_case("err_lhu_17",  1'b0, F3_HU,  32'h17);
    check("err_word8_kept", ram[8], 32'hBEEF_55EF);

    // Reset during the WRITE cycle of an sb must abort it silently.
    bd_load(16'd9, 32'h0102_0304);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h24; bus.req_store_data = 32'h0000_0077;
    step();
    bus.req_valid = 1'b0;
    check("abort_read_state", 32'(dbg_state), 32'(ST_READ));
    step();
    check("abort_write_state", 32'(dbg_state), 32'(ST_WRITE));
    check("abort_write_din", bus.ram_data_in, 32'h0102_0377);
    check("abort_write_addr", 32'(bus.ram_endereco), 32'd9);
    reset = 1'b1;
    #1;
    check("abort_we_gated", 32'(bus.ram_write_enable), 32'd0);
    step();
    reset = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_resp_error", 32'(bus.resp_error), 32'd0);
    check("abort_ld", bus.resp_load_data, 32'd0);
    check("abort_we", 32'(bus.ram_write_enable), 32'd0);
    check("abort_addr", 32'(bus.ram_endereco), 32'd0);
    check("abort_din", bus.ram_data_in, 32'd0);
    check("abort_word9", ram[9], 32'h0102_0304);
    step();
    check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    check("abort_word9_later", ram[9], 32'h0102_0304);

    // Back-to-back with req_valid held high.
    bd_load(16'd10, 32'hFFFF_FFFF);
    seq_wr[0] = 1'b0; seq_f3[0] = F3_W;  seq_addr[0] = 32'h14; seq_data[0] = 32'h0;          seq_ld[0] = 32'h8070_F0A5;
    seq_wr[1] = 1'b1; seq_f3[1] = F3_B;  seq_addr[1] = 32'h28; seq_data[1] = 32'h0000_005A;  seq_ld[1] = 32'h0;
    seq_wr[2] = 1'b0; seq_f3[2] = F3_HU; seq_addr[2] = 32'h16; seq_data[2] = 32'h0;          seq_ld[2] = 32'h0000_8070;
    seq_wr[3] = 1'b1; seq_f3[3] = F3_W;  seq_addr[3] = 32'h2C; seq_data[3] = 32'h1357_9BDF;  seq_ld[3] = 32'h0;
    seq_wr[4] = 1'b0; seq_f3[4] = F3_B;  seq_addr[4] = 32'h15; seq_data[4] = 32'h0;          seq_ld[4] = 32'hFFFF_FFF0;
    seq_gap[0] = 3; seq_gap[1] = 4; seq_gap[2] = 3; seq_gap[3] = 3;
    run_b2b();
    step();
    check("b2b_word10", ram[10], 32'hFFFF_FF5A);
    check("b2b_word11", ram[11], 32'h1357_9BDF);
    check("b2b_idle", 32'(dbg_state), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit for the MEM stage of the RISC-V pipeline, sitting directly upstream of the 64K×32 data RAM (`Mem_RAM`). It accepts one byte-addressed load/store request at a time. It checks alignment and range, converts byte addresses to word addresses, and performs read-modify-write for `sb`/`sh`, because the RAM has no byte enables. It returns sign- or zero-extended load data and an error flag to the pipeline.

## Interface
- `ADDR_W`, 16, RAM word-address width (RAM depth 2^ADDR_W words).
- `clock` in 1, single clock; all state updates on its rising edge.
- `reset` in 1, synchronous, active-high.
- `req_valid` in 1, request present.
- `req_ready` out 1, unit idle and able to accept.
- `req_write` in 1, 1 = store, 0 = load.
- `req_funct3` in 3, RV32I funct3 of the load/store.
- `req_addr` in 32, byte address.
- `req_store_data` in 32, store operand (rs2).
- `resp_valid` out 1, one-cycle pulse: request complete.
- `resp_error` out 1, qualifies `resp_valid`: request rejected, no RAM access.
- `resp_load_data` out 32, extended load result, valid with `resp_valid` on a good load.
- `ram_write_enable` out 1, to the RAM's `write_enable`.
- `ram_endereco` out ADDR_W, to the RAM's address port.
- `ram_data_in` out 32, to the RAM's `data_in`.
- `ram_data_out` in 32, from the RAM; registered, valid the cycle after the address is presented.

## Operation
- The unit is an FSM with states IDLE, READ, WRITE and RESP. `req_ready` = (state == IDLE).
- **Acceptance:** a request is accepted at the edge where `req_valid && req_ready`. The address, funct3, data and write flag are captured in registers.
- **Valid encodings:**
  - Loads: 000 `lb`, 001 `lh`, 010 `lw`, 100 `lbu`, 101 `lhu`.
  - Stores: 000 `sb`, 001 `sh`, 010 `sw`.
  - Any other funct3 is an error.
- **Error conditions:**
  - Misalignment: word access with `addr[1:0]` ≠ 0, or halfword access with `addr[0]` ≠ 0.
  - Out of range: `addr[31:ADDR_W+2]` ≠ 0.
  - An error takes IDLE → RESP with `resp_error` = 1 and no RAM access.
- **Transitions for good requests:**
  - Load: IDLE → READ → RESP → IDLE.
  - `sw`: IDLE → WRITE → RESP → IDLE.
  - `sb`/`sh`: IDLE → READ → WRITE → RESP → IDLE.
- **RAM outputs:**
  - `ram_endereco` = captured `addr[ADDR_W+1:2]` in READ and WRITE.
  - `ram_write_enable` = (state == WRITE) && !`reset`.
  - All RAM outputs are 0 in IDLE and RESP.
- **Write data in WRITE:**
  - `sw`: the captured store data.
  - `sb`: `ram_data_out` with byte lane `addr[1:0]` replaced by `store_data[7:0]`.
  - `sh`: `ram_data_out` with halfword lane `addr[1]` replaced by `store_data[15:0]`.
- **Lane order:** little-endian; byte k occupies bits [8k+7:8k].
- **Load data in RESP:** lane selected from `ram_data_out` by the captured `addr[1:0]`. `lb`/`lh` sign-extend; `lbu`/`lhu` zero-extend; `lw` passes through.
- **Output hygiene:** `resp_load_data` is 0 whenever `resp_valid` is 0, on errors and on stores.

## Timing
- **Reset:** state = IDLE, `req_ready` = 1. `resp_valid`, `resp_error`, `resp_load_data`, `ram_write_enable`, `ram_endereco` and `ram_data_in` are all 0.
- **Latency, counted from the acceptance edge E0:**
  - Load: `resp_valid` in the cycle after E1.
  - `sw`: the RAM write happens at E1; `resp_valid` in the cycle after E1.
  - `sb`/`sh`: read at E1, write at E2; `resp_valid` in the cycle after E2.
  - Error: `resp_valid` + `resp_error` in the cycle after E0.
- **Back-to-back:** `req_ready` rises in the cycle after RESP. Minimum spacing between accepted requests is 3 cycles for loads/`sw` and 4 for `sb`/`sh`.
- `req_*` inputs are ignored while `req_ready` = 0; the captured copies are used throughout.
- **Reset mid-operation:** if reset is high in a WRITE cycle, no RAM write occurs. The unit returns to IDLE at that edge and no response is issued for the aborted request.
- **RAM read-before-write:** the RAM's `data_out` returns the old word on the write edge. The unit never consumes `ram_data_out` after a WRITE.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - FSM state encoding.
  - `XLEN` = 32.
- Natural sub-module: `mem_align_ext`, a combinational lane selector, load extender and store merger, shared by the READ-side and WRITE-side paths.

## Test plan
- Preload word 5 = 0x8070_F0A5; `lb` @0x15 → `resp_load_data` = 0xFFFF_FFF0. `lbu` @0x15 → 0x0000_00F0. `lh` @0x16 → 0xFFFF_8070.
- `sw` 0xDEAD_BEEF @0x20, then `lw` @0x20 → write at E1, `resp_valid` in the cycle after E1, read returns 0xDEAD_BEEF.
- Word 8 = 0x1122_3344; `sb` 0xAB @0x23 → word 8 = 0xAB22_3344. `sh` 0xCDEF @0x20 → 0xAB22_CDEF. `resp_valid` in the cycle after E2 in both cases.
- `lw` @0x22, `sh` @0x21, funct3 = 011, and `lw` @0x0004_0000 → each gives `resp_error` = 1 in the cycle after acceptance, with `ram_write_enable` never asserted.
- Assert `reset` during the WRITE cycle of an `sb` → RAM word unchanged, state IDLE, all outputs 0 in the next cycle.
- Hold `req_valid` = 1 with alternating load/store → exactly one acceptance per `req_ready` pulse, and spacing of 3 or 4 cycles as specified.
